// File: rtl/rram_access_seq.sv
// rram_access_seq: one-command-at-a-time access sequencer for the rram_simu
// crossbar model. It drives the WL/BL/SL selects, precharge, CSA and ADC
// controls through timed phases and captures the sense results into a response.
// Optional write-verify pass: define RRAM_SEQ_VERIFY_EN.
module rram_access_seq #(
  parameter int unsigned T_PRE = 4,
  parameter int unsigned T_DEV = 8,
  parameter int unsigned T_ADC = 16,
  parameter int unsigned T_WR  = 20,
  parameter int unsigned CNT_W = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_OP,
  input  logic [15:0] CMD_WL,
  input  logic [15:0] CMD_BL,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic        RSP_ERR,
  output logic        RSP_VERIFY_OK,
  output logic [15:0] RSP_CSA,
  output logic [15:0] RSP_ADC0,
  output logic [15:0] RSP_ADC1,
  output logic [15:0] RSP_ADC2,
  output logic        ENABLE_WL,
  output logic        ENABLE_BL,
  output logic        ENABLE_SL,
  output logic        ENABLE_CSA,
  output logic        ENABLE_ADC,
  output logic        PRE,
  output logic        SAEN_CSA,
  output logic [1:0]  CLK_EN_ADC,
  output logic [15:0] IN0_WL,
  output logic [15:0] IN0_BL,
  output logic [15:0] IN0_SL,
  output logic [15:0] IN1_WL,
  output logic [15:0] IN1_BL,
  output logic [15:0] IN1_SL,
  input  logic [15:0] CSA,
  input  logic [15:0] ADC_OUT0,
  input  logic [15:0] ADC_OUT1,
  input  logic [15:0] ADC_OUT2
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_PRECHG, S_DEVELOP, S_SENSE,
    S_CONVERT, S_CAPTURE, S_PULSE, S_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_SET   = 2'b01,
    OP_RESET = 2'b10,
    OP_ILL   = 2'b11
  } op_e;

  localparam logic [CNT_W-1:0] PRE_LD = CNT_W'(T_PRE - 1);
  localparam logic [CNT_W-1:0] DEV_LD = CNT_W'(T_DEV - 1);
  localparam logic [CNT_W-1:0] ADC_LD = CNT_W'(T_ADC - 1);
  localparam logic [CNT_W-1:0] WR_LD  = CNT_W'(T_WR - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_q;
  logic             ver_q, ver_d;
  op_e              op_q;
  logic [15:0]      wl_q, bl_q;
  logic             err_q;
  logic [15:0]      rsp_csa_q, rsp_adc0_q, rsp_adc1_q, rsp_adc2_q;
  logic             accept, capture, cmd_bad;
  logic             drive_on, rd_mode;

  // Next-state and phase counter: counter is loaded on phase entry, phase ends at 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ver_d   = ver_q;
    accept  = 1'b0;
    capture = 1'b0;
    cmd_bad = (CMD_OP == OP_ILL) || (CMD_WL == '0);
    unique case (state_q)
      S_IDLE: begin
        if (CMD_VALID && rdy_q) begin
          accept  = 1'b1;
          ver_d   = 1'b0;
          state_d = cmd_bad ? S_RESP : S_SETUP;
        end
      end
      S_SETUP: begin
        if (op_q == OP_READ || ver_q) begin
          state_d = S_PRECHG;
          cnt_d   = PRE_LD;
        end else begin
          state_d = S_PULSE;
          cnt_d   = WR_LD;
        end
      end
      S_PRECHG: begin
        if (cnt_q == '0) begin
          state_d = S_DEVELOP;
          cnt_d   = DEV_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DEVELOP: begin
        if (cnt_q == '0) state_d = S_SENSE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_SENSE: begin
        state_d = S_CONVERT;
        cnt_d   = ADC_LD;
      end
      S_CONVERT: begin
        if (cnt_q == '0) state_d = S_CAPTURE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_CAPTURE: begin
        capture = 1'b1;
        state_d = S_RESP;
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
`ifdef RRAM_SEQ_VERIFY_EN
          // Write-verify reuses the read phases; ver_q forces read encoding in SETUP
          ver_d   = 1'b1;
          state_d = S_SETUP;
`else
          state_d = S_RESP;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (RSP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, latched command and response registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rdy_q      <= 1'b0;
      ver_q      <= 1'b0;
      op_q       <= OP_READ;
      wl_q       <= '0;
      bl_q       <= '0;
      err_q      <= 1'b0;
      rsp_csa_q  <= '0;
      rsp_adc0_q <= '0;
      rsp_adc1_q <= '0;
      rsp_adc2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Registered so ready stays low throughout reset and rises one edge after release
      rdy_q   <= (state_d == S_IDLE);
      ver_q   <= ver_d;
      if (accept) begin
        op_q       <= op_e'(CMD_OP);
        wl_q       <= CMD_WL;
        bl_q       <= CMD_BL;
        err_q      <= cmd_bad;
        rsp_csa_q  <= '0;
        rsp_adc0_q <= '0;
        rsp_adc1_q <= '0;
        rsp_adc2_q <= '0;
      end
      if (capture) begin
        rsp_csa_q  <= CSA;
        rsp_adc0_q <= ADC_OUT0;
        rsp_adc1_q <= ADC_OUT1;
        rsp_adc2_q <= ADC_OUT2;
      end
    end
  end

`ifdef RRAM_SEQ_VERIFY_EN
  logic vok_q;

  // Verify verdict: every selected bit line must read 1 after SET, 0 after RESET
  always_ff @(posedge CLK) begin
    if (RST) begin
      vok_q <= 1'b0;
    end else if (accept) begin
      vok_q <= 1'b0;
    end else if (capture) begin
      vok_q <= ver_q && ((op_q == OP_SET) ? ((CSA & bl_q) == bl_q)
                                          : ((CSA & bl_q) == '0));
    end
  end

  assign RSP_VERIFY_OK = vok_q;
`else
  assign RSP_VERIFY_OK = 1'b0;
`endif

  // Array drives decode from state and the latched command only
  always_comb begin
    drive_on = (state_q == S_SETUP)   || (state_q == S_PRECHG)  ||
               (state_q == S_DEVELOP) || (state_q == S_SENSE)   ||
               (state_q == S_CONVERT) || (state_q == S_PULSE);
    rd_mode  = (op_q == OP_READ) || ver_q;

    ENABLE_WL  = drive_on;
    ENABLE_BL  = drive_on;
    ENABLE_SL  = drive_on;
    IN0_WL     = drive_on ? wl_q : '0;
    IN0_BL     = drive_on ? bl_q : '0;
    IN0_SL     = '0;
    IN1_WL     = '0;
    IN1_BL     = (drive_on && !rd_mode && op_q == OP_SET)   ? bl_q : '0;
    IN1_SL     = (drive_on && !rd_mode && op_q == OP_RESET) ? bl_q : '0;
    PRE        = (state_q == S_PRECHG);
    ENABLE_CSA = (state_q == S_SENSE);
    SAEN_CSA   = (state_q == S_SENSE);
    ENABLE_ADC = (state_q == S_CONVERT);
    CLK_EN_ADC = {(state_q == S_CONVERT) && (cnt_q == '0), state_q == S_CONVERT};
  end

  assign CMD_READY = rdy_q;
  assign RSP_VALID = (state_q == S_RESP);
  assign RSP_ERR   = err_q;
  assign RSP_CSA   = rsp_csa_q;
  assign RSP_ADC0  = rsp_adc0_q;
  assign RSP_ADC1  = rsp_adc1_q;
  assign RSP_ADC2  = rsp_adc2_q;

endmodule

// File: tb/tb_rram_access_seq.sv
// Directed self-checking bench for rram_access_seq (defaults: 4/8/16/20).
// Expected write latency and verify results follow RRAM_SEQ_VERIFY_EN.
module tb_rram_access_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CMD_VALID = 1'b0, CMD_READY;
  logic [1:0]  CMD_OP = 2'b00;
  logic [15:0] CMD_WL = '0, CMD_BL = '0;
  logic        RSP_VALID, RSP_READY = 1'b0, RSP_ERR, RSP_VERIFY_OK;
  logic [15:0] RSP_CSA, RSP_ADC0, RSP_ADC1, RSP_ADC2;
  logic        ENABLE_WL, ENABLE_BL, ENABLE_SL, ENABLE_CSA, ENABLE_ADC, PRE, SAEN_CSA;
  logic [1:0]  CLK_EN_ADC;
  logic [15:0] IN0_WL, IN0_BL, IN0_SL, IN1_WL, IN1_BL, IN1_SL;
  logic [15:0] CSA = '0, ADC_OUT0 = '0, ADC_OUT1 = '0, ADC_OUT2 = '0;

  int total = 0;
  int bad   = 0;

`ifdef RRAM_SEQ_VERIFY_EN
  localparam bit VER = 1'b1;
  localparam int WR_LAT = 53;
`else
  localparam bit VER = 1'b0;
  localparam int WR_LAT = 22;
`endif

  logic [104:0] drv;
  logic [65:0]  rspv;
  assign drv  = {ENABLE_WL, ENABLE_BL, ENABLE_SL, ENABLE_CSA, ENABLE_ADC, PRE, SAEN_CSA,
                 CLK_EN_ADC, IN0_WL, IN0_BL, IN0_SL, IN1_WL, IN1_BL, IN1_SL};
  assign rspv = {RSP_ERR, RSP_VERIFY_OK, RSP_CSA, RSP_ADC0, RSP_ADC1, RSP_ADC2};

  rram_access_seq #(.T_PRE(4), .T_DEV(8), .T_ADC(16), .T_WR(20), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_WL(CMD_WL), .CMD_BL(CMD_BL),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ERR(RSP_ERR),
    .RSP_VERIFY_OK(RSP_VERIFY_OK), .RSP_CSA(RSP_CSA),
    .RSP_ADC0(RSP_ADC0), .RSP_ADC1(RSP_ADC1), .RSP_ADC2(RSP_ADC2),
    .ENABLE_WL(ENABLE_WL), .ENABLE_BL(ENABLE_BL), .ENABLE_SL(ENABLE_SL),
    .ENABLE_CSA(ENABLE_CSA), .ENABLE_ADC(ENABLE_ADC), .PRE(PRE),
    .SAEN_CSA(SAEN_CSA), .CLK_EN_ADC(CLK_EN_ADC),
    .IN0_WL(IN0_WL), .IN0_BL(IN0_BL), .IN0_SL(IN0_SL),
    .IN1_WL(IN1_WL), .IN1_BL(IN1_BL), .IN1_SL(IN1_SL),
    .CSA(CSA), .ADC_OUT0(ADC_OUT0), .ADC_OUT1(ADC_OUT1), .ADC_OUT2(ADC_OUT2)
  );

  always #5 CLK = ~CLK;

  // Called at a negedge; returns just after the accept edge (cycle 0).
  task automatic issue(input logic [1:0] op, input logic [15:0] wl, input logic [15:0] bl);
    int n = 0;
    while (CMD_READY !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (CMD_READY !== 1'b1) begin
      bad++;
      $display("FAIL issue_ready: got %b want 1", CMD_READY);
    end
    CMD_VALID = 1'b1; CMD_OP = op; CMD_WL = wl; CMD_BL = bl;
    @(posedge CLK);
    #1;
    // Scramble inputs so drives can only come from the latched command
    CMD_VALID = 1'b0; CMD_OP = 2'b11; CMD_WL = 16'hFFFF; CMD_BL = 16'hFFFF;
  endtask

  // Called at the negedge where RSP_VALID is seen; ends at a negedge in IDLE.
  task automatic consume();
    RSP_READY = 1'b1;
    @(posedge CLK);
    #1 RSP_READY = 1'b0;
    @(negedge CLK);
    total++;
    if (RSP_VALID !== 1'b0 || CMD_READY !== 1'b1) begin
      bad++;
      $display("FAIL consume: got valid=%b ready=%b want valid=0 ready=1", RSP_VALID, CMD_READY);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total++;
    if ({drv, rspv, RSP_VALID, CMD_READY} !== '0) begin
      bad++;
      $display("FAIL reset_hold: got drv=%h rsp=%h v=%b r=%b want all 0", drv, rspv, RSP_VALID, CMD_READY);
    end
    RST = 1'b0;
    @(negedge CLK);
    total++;
    if (CMD_READY !== 1'b1 || drv !== '0 || RSP_VALID !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got ready=%b drv=%h valid=%b want 1/0/0", CMD_READY, drv, RSP_VALID);
    end
    issue(2'b00, 16'h0001, 16'h00FF);
    for (int c = 1; c <= 10; c++) @(negedge CLK);
    total++;
    if (ENABLE_WL !== 1'b1) begin
      bad++;
      $display("FAIL reset_midop_active: got ENABLE_WL=%b want 1", ENABLE_WL);
    end
    RST = 1'b1;
    @(negedge CLK);
    total++;
    if (drv !== '0 || RSP_VALID !== 1'b0) begin
      bad++;
      $display("FAIL reset_midop: got drv=%h valid=%b want 0/0", drv, RSP_VALID);
    end
    RST = 1'b0;
    @(negedge CLK);
    total++;
    if (CMD_READY !== 1'b1 || drv !== '0) begin
      bad++;
      $display("FAIL reset_midop_idle: got ready=%b drv=%h want 1/0", CMD_READY, drv);
    end
  endtask

  task automatic test_read();
    logic       e_pre, e_saen, e_vld;
    logic [1:0] e_clk;
    logic [15:0] e_wl;
    CSA = 16'h00A5; ADC_OUT0 = 16'h0123; ADC_OUT1 = 16'h4567; ADC_OUT2 = 16'h89AB;
    issue(2'b00, 16'h0001, 16'h00FF);
    for (int c = 1; c <= 32; c++) begin
      @(negedge CLK);
      e_pre  = (c >= 2 && c <= 5);
      e_saen = (c == 14);
      e_clk  = (c == 30) ? 2'b11 : ((c >= 15 && c < 30) ? 2'b01 : 2'b00);
      e_wl   = (c <= 30) ? 16'h0001 : 16'h0000;
      e_vld  = (c == 32);
      total++;
      if (PRE !== e_pre) begin
        bad++; $display("FAIL read_pre c=%0d: got %b want %b", c, PRE, e_pre);
      end
      total++;
      if (SAEN_CSA !== e_saen) begin
        bad++; $display("FAIL read_saen c=%0d: got %b want %b", c, SAEN_CSA, e_saen);
      end
      total++;
      if (CLK_EN_ADC !== e_clk) begin
        bad++; $display("FAIL read_clken c=%0d: got %b want %b", c, CLK_EN_ADC, e_clk);
      end
      total++;
      if (IN0_WL !== e_wl || IN1_BL !== 16'h0000 || IN1_SL !== 16'h0000) begin
        bad++; $display("FAIL read_drv c=%0d: got wl=%h in1bl=%h in1sl=%h want %h/0/0", c, IN0_WL, IN1_BL, IN1_SL, e_wl);
      end
      total++;
      if (RSP_VALID !== e_vld) begin
        bad++; $display("FAIL read_valid c=%0d: got %b want %b", c, RSP_VALID, e_vld);
      end
    end
    total++;
    if (rspv !== {1'b0, 1'b0, 16'h00A5, 16'h0123, 16'h4567, 16'h89AB}) begin
      bad++; $display("FAIL read_rsp: got %h want %h", rspv, {2'b00, 16'h00A5, 16'h0123, 16'h4567, 16'h89AB});
    end
    consume();
  endtask

  task automatic test_write(input logic [1:0] op, input logic [15:0] wl, input logic [15:0] bl,
                            input logic [15:0] csa_m, input logic e_ok);
    logic [15:0] e_in1;
    logic        e_en;
    CSA = csa_m; ADC_OUT0 = 16'h3C3C;
    issue(op, wl, bl);
    for (int c = 1; c <= WR_LAT; c++) begin
      @(negedge CLK);
      e_in1 = (c <= 21) ? bl : 16'h0000;
      e_en  = (c <= 21) || (VER && c <= 51);
      total++;
      if (op == 2'b01 ? (IN1_BL !== e_in1 || IN1_SL !== 16'h0000)
                      : (IN1_SL !== e_in1 || IN1_BL !== 16'h0000)) begin
        bad++; $display("FAIL write_in1 op=%b c=%0d: got bl=%h sl=%h want %h on op line", op, c, IN1_BL, IN1_SL, e_in1);
      end
      total++;
      if (ENABLE_WL !== e_en || IN0_WL !== (e_en ? wl : 16'h0000)) begin
        bad++; $display("FAIL write_wl op=%b c=%0d: got en=%b wl=%h want %b", op, c, ENABLE_WL, IN0_WL, e_en);
      end
      total++;
      if (RSP_VALID !== (c == WR_LAT)) begin
        bad++; $display("FAIL write_valid op=%b c=%0d: got %b want %b", op, c, RSP_VALID, c == WR_LAT);
      end
    end
    total++;
    if (RSP_ERR !== 1'b0 || RSP_VERIFY_OK !== e_ok) begin
      bad++; $display("FAIL write_flags op=%b: got err=%b ok=%b want 0/%b", op, RSP_ERR, RSP_VERIFY_OK, e_ok);
    end
    total++;
    if (RSP_CSA !== (VER ? csa_m : 16'h0000) || RSP_ADC0 !== (VER ? 16'h3C3C : 16'h0000)) begin
      bad++; $display("FAIL write_data op=%b: got csa=%h adc0=%h", op, RSP_CSA, RSP_ADC0);
    end
    consume();
  endtask

  task automatic test_error();
    logic [1:0]  ops [2] = '{2'b11, 2'b00};
    logic [15:0] wls [2] = '{16'h0001, 16'h0000};
    for (int i = 0; i < 2; i++) begin
      CSA = 16'h7777;
      issue(ops[i], wls[i], 16'h00FF);
      @(negedge CLK);
      total++;
      if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b1) begin
        bad++; $display("FAIL error_rsp i=%0d: got valid=%b err=%b want 1/1", i, RSP_VALID, RSP_ERR);
      end
      total++;
      if (drv !== '0 || RSP_CSA !== 16'h0000) begin
        bad++; $display("FAIL error_quiet i=%0d: got drv=%h csa=%h want 0/0", i, drv, RSP_CSA);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [65:0] e_rsp;
    e_rsp = {2'b00, 16'h00A5, 16'h0123, 16'h4567, 16'h89AB};
    CSA = 16'h00A5; ADC_OUT0 = 16'h0123; ADC_OUT1 = 16'h4567; ADC_OUT2 = 16'h89AB;
    issue(2'b00, 16'h0002, 16'h000F);
    for (int c = 1; c <= 32; c++) @(negedge CLK);
    CSA = 16'h5A5A; ADC_OUT0 = 16'hDEAD;
    for (int k = 0; k < 10; k++) begin
      total++;
      if (RSP_VALID !== 1'b1 || CMD_READY !== 1'b0 || rspv !== e_rsp) begin
        bad++; $display("FAIL bp_hold k=%0d: got v=%b r=%b rsp=%h want 1/0/%h", k, RSP_VALID, CMD_READY, rspv, e_rsp);
      end
      if (k == 4) begin
        CMD_VALID = 1'b1; CMD_OP = 2'b01; CMD_WL = 16'h0001; CMD_BL = 16'h0001;
      end else begin
        CMD_VALID = 1'b0;
      end
      @(negedge CLK);
    end
    CMD_VALID = 1'b0;
    consume();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      total++;
      if (drv !== '0 || CMD_READY !== 1'b1 || RSP_VALID !== 1'b0) begin
        bad++; $display("FAIL bp_ignored k=%0d: got drv=%h r=%b v=%b want 0/1/0", k, drv, CMD_READY, RSP_VALID);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write(2'b01, 16'h8000, 16'h0003, 16'h0003, VER);
    test_error();
    test_backpressure();
    test_write(2'b10, 16'h0001, 16'h0001, 16'h0000, VER);
    test_write(2'b10, 16'h0001, 16'h0001, 16'h0001, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/rram_access_seq.md
# rram_access_seq

Upstream access sequencer for the `rram_simu` crossbar model. It accepts one READ/SET/RESET command at a time over a valid/ready handshake, drives the array's WL/BL/SL selects, PRE, CSA and ADC controls through a timed state machine, and captures the CSA/ADC outputs into a response. Test benches and the future MAC controller talk to the array only through this block.

## Interface
Parameters:
- `T_PRE`, 4: precharge cycles, legal range ≥1
- `T_DEV`, 8: bit-line develop cycles, legal range ≥1
- `T_ADC`, 16: ADC conversion cycles, legal range ≥2
- `T_WR`, 20: SET/RESET pulse cycles, legal range ≥1
- `CNT_W`, 8: phase counter width; every `T_*` must be < 2^CNT_W

Ports (`CLK`, `RST`: one clock; reset is synchronous and active-high):
- `CLK` in 1: clock
- `RST` in 1: synchronous active-high reset
- `CMD_VALID` in 1, `CMD_READY` out 1: command handshake
- `CMD_OP` in 2: 00 READ, 01 SET, 10 RESET, 11 illegal
- `CMD_WL`, `CMD_BL` in 16: row mask, column mask
- `RSP_VALID` out 1, `RSP_READY` in 1: response handshake
- `RSP_ERR` out 1: command rejected
- `RSP_VERIFY_OK` out 1: write verify passed
- `RSP_CSA` out 16: captured CSA
- `RSP_ADC0..2` out 16 each: captured ADC_OUT0..2
- Array side, out: `ENABLE_WL/BL/SL/CSA/ADC` (1 each), `PRE` 1, `SAEN_CSA` 1, `CLK_EN_ADC` 2, `IN0_/IN1_ WL/BL/SL` 16 each
- Array side, in: `CSA` 16, `ADC_OUT0..2` 16 each

## Operation
- States: IDLE, SETUP, PRECHG, DEVELOP, SENSE, CONVERT, CAPTURE, PULSE, RESP.
- IDLE: `CMD_READY`=1. A command is accepted on `CMD_VALID&CMD_READY`, and the op and masks are latched.
- Illegal op or `CMD_WL`==0: go straight to RESP with `RSP_ERR`=1. No array signal toggles.
- SETUP (1 cycle): `IN0_WL`=WL mask, `IN0_BL`=BL mask, and all ENABLE_WL/BL/SL=1.
  - READ: `IN1_*`=0, `IN0_SL`=0, then go to PRECHG.
  - SET: `IN1_BL`=BL mask, then go to PULSE.
  - RESET: `IN1_SL`=BL mask, then go to PULSE.
- PRECHG: `PRE`=1 for T_PRE cycles.
- DEVELOP: T_DEV cycles with WL held.
- SENSE: 1 cycle, with `ENABLE_CSA`=1 and `SAEN_CSA`=1.
- CONVERT: T_ADC cycles with `ENABLE_ADC`=1 and `CLK_EN_ADC[0]`=1. `CLK_EN_ADC[1]`=1 only in the last CONVERT cycle.
- CAPTURE: 1 cycle. `CSA` and `ADC_OUT0..2` are registered into the RSP_* registers, and all array drives return to 0.
- PULSE: T_WR cycles, then go to RESP (or verify, see Configuration).
- RESP: `RSP_VALID`=1. RSP_* stay stable until `RSP_READY`, then go to IDLE. `CMD_READY` rises the next cycle.
- `CMD_READY`=0 in every state except IDLE. No command queuing.
- One down-counter (CNT_W bits) times every phase. It is loaded with T_x−1 on phase entry, and the phase exits when the counter is 0.

## Timing
- Reset value: every output is 0, except `CMD_READY`=1, which becomes visible in the first cycle after RST deasserts. The state is IDLE.
- RST asserted mid-operation: the next edge zeroes all array drives and RSP_* and returns to IDLE. Any partial response is discarded.
- Cycle numbering: the accept edge is cycle 0.
- READ latency: SETUP at cycle 1, then PRECHG, DEVELOP, SENSE, CONVERT and CAPTURE. `RSP_VALID` first high at cycle T_PRE+T_DEV+T_ADC+4, which is 32 with defaults.
- SET/RESET latency: `RSP_VALID` first high at cycle T_WR+2, which is 22 with defaults.
- Error latency: `RSP_VALID` at cycle 1.
- `RSP_READY` high while RSP_VALID is high: the response is consumed at that edge. Back-to-back commands have at least one IDLE cycle between them.
- `CMD_VALID` while busy: ignored and not latched.
- A command's masks must not change array drives mid-command; drives come only from the latched copy.

## Configuration
- `RRAM_SEQ_VERIFY_EN` defined:
  - After PULSE, a read pass runs (SETUP with READ encoding through CAPTURE) on the same WL/BL masks.
  - `RSP_VERIFY_OK`=1 iff, for every set bit of the BL mask, captured `CSA` is 1 for SET or 0 for RESET.
  - Write latency becomes T_WR+1+T_PRE+T_DEV+T_ADC+4, which is 53 with defaults.
- Macro undefined: the verify pass is absent, `RSP_VERIFY_OK` is tied to 0, and RSP_CSA/ADC read 0 after a write.

## Test plan
- Reset: hold RST for 3 cycles, then release → all outputs 0 and CMD_READY=1. Issue a READ, assert RST at cycle 10 → the next cycle has all drives 0 and the state is IDLE.
- READ with WL=16'h0001, BL=16'h00FF, model CSA=16'h00A5 and ADC_OUT0=16'h0123:
  - PRE high cycles 2–5, SAEN_CSA high only in cycle 14, CLK_EN_ADC=2'b11 only in cycle 30.
  - RSP_VALID at cycle 32 with RSP_CSA=16'h00A5 and RSP_ADC0=16'h0123.
- SET with WL=16'h8000, BL=16'h0003 → IN1_BL=16'h0003 for cycles 1–21, and RSP_VALID at cycle 22 with RSP_ERR=0.
- Illegal op 2'b11, then WL=0 → each gives RSP_VALID at cycle 1 with RSP_ERR=1, and no ENABLE_* or PRE activity.
- Backpressure: hold RSP_READY low for 10 cycles → RSP_* stable and CMD_READY=0; a CMD_VALID pulse during the hold is ignored.
- With RRAM_SEQ_VERIFY_EN, RESET with BL=16'h0001:
  - model CSA=0 → RSP_VERIFY_OK=1 at cycle 53.
  - model CSA=1 → RSP_VERIFY_OK=0.
